// File: rtl/serial_parity_unit.sv
// Serial parity accumulator: accepts a WIDTH-bit word, folds one bit per clock through an XOR
// into a single parity bit, and presents the result on a valid/ready output handshake.
module serial_parity_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             odd_mode,
  output logic             out_valid,
  output logic             out_parity,
  input  logic             out_ready
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sh;
  logic             r_acc;
  logic [CntW-1:0]  r_cnt;

  logic [1:0]       w_state_d;
  logic [WIDTH-1:0] w_sh_d;
  logic             w_acc_d;
  logic [CntW-1:0]  w_cnt_d;

  always_comb begin
    w_state_d = r_state;
    w_sh_d    = r_sh;
    w_acc_d   = r_acc;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_sh_d    = in_data;
          w_acc_d   = odd_mode;
          w_cnt_d   = '0;
          w_state_d = StShift;
        end
      end
      StShift: begin
        w_acc_d = r_acc ^ r_sh[0];
        w_sh_d  = r_sh >> 1;
        // Counter saturates at the last bit index instead of wrapping.
        if (r_cnt == LastCnt) begin
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sh    <= '0;
      r_acc   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_sh    <= w_sh_d;
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Handshake outputs decode the state register only; parity comes straight from the register.
  assign in_ready   = (r_state == StIdle);
  assign out_valid  = (r_state == StDone);
  assign out_parity = r_acc;

endmodule

// File: doc/serial_parity_unit.md
# serial_parity_unit

Serial parity accumulator that consumes a WIDTH-bit word over a valid/ready handshake and folds it, one bit per clock, through a 2-input XOR stage into a single parity bit. It sits directly downstream of the 2-input XOR cell. It is the sequential wrapper that turns that combinational cell into a word-level even/odd parity generator. Results leave on a second valid/ready handshake, so the block can feed a serial transmitter or a parity checker.

## Interface
Parameters:
- WIDTH, default 8: data word width in bits; legal range 2..32.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low. This is fixed: one clock, reset asynchronous and active-low.
- in_valid, input, 1: upstream word present on in_data.
- in_ready, output, 1: block can accept a word this cycle.
- in_data, input, WIDTH: word to fold.
- odd_mode, input, 1: parity sense.
  - 0 selects even parity: out_parity = XOR of all bits.
  - 1 selects odd parity: out_parity = inverted XOR of all bits.
  - Sampled only on the accept edge.
- out_valid, output, 1: out_parity holds a finished result.
- out_parity, output, 1: parity result; stable while out_valid=1.
- out_ready, input, 1: downstream takes the result.

## Operation
State machine: IDLE, SHIFT, DONE.

IDLE:
- in_ready=1, out_valid=0.
- Accept when in_valid=1 at a rising edge. On that edge:
  - shift register <= in_data.
  - acc <= odd_mode.
  - bit counter <= 0.
  - state -> SHIFT.
- in_valid=0: stay in IDLE; no register changes.

SHIFT:
- in_ready=0, out_valid=0.
- On each edge:
  - acc <= acc XOR sh[0].
  - sh <= sh >> 1, zero-filled.
  - counter <= counter + 1.
- When counter == WIDTH-1 on an edge, that edge performs the final fold and sets state -> DONE.
- Counter width is $clog2(WIDTH); it never wraps past WIDTH-1.

DONE:
- out_valid=1, out_parity=acc, in_ready=0.
- out_ready=1 at an edge: state -> IDLE.
- out_ready=0: hold the result indefinitely. Backpressure never corrupts or drops the result.

Other rules:
- in_data and odd_mode are ignored outside the IDLE accept edge.
- Upstream changing in_data while in_ready=0 has no effect.
- There is no bypass: a new word cannot be accepted on the same edge a result is consumed. in_ready rises only in the cycle after the DONE -> IDLE edge.
- out_parity is driven directly from the acc register; no combinational path exists from any input to any output.
- in_ready and out_valid are decoded from the state register only.

Reset:
- Asserting rst_n=0 asynchronously forces:
  - state=IDLE.
  - sh=0, acc=0, counter=0.
  - in_ready=1, out_valid=0, out_parity=0.
- Reset mid-SHIFT or mid-DONE aborts the word with no output. The first accept is possible on the first rising edge after rst_n deasserts.

## Timing
- Accept edge E0. Fold edges E1..E_WIDTH. out_valid=1 starting after edge E_WIDTH, i.e. latency WIDTH cycles from accept to result.
- Minimum period per word is WIDTH+2 cycles with out_ready tied high: accept edge, WIDTH fold edges, consume edge, then an IDLE cycle.
- in_ready and out_valid are never both 1.
- in_ready=1 implies state=IDLE.

## Test plan
1. Reset: hold rst_n=0 for 3 cycles -> in_ready=1, out_valid=0, out_parity=0. Deasserting rst_n asynchronously mid-cycle does not glitch in_ready.
2. Even parity, WIDTH=8, out_ready=1:
   - in_data=0x00 -> out_parity=0.
   - 0x01 -> 1.
   - 0xA5 -> 0.
   - 0x07 -> 1.
   - 0xFF -> 0.
   - Each result appears exactly 8 cycles after its accept edge.
3. Odd parity: odd_mode=1 with 0xA5 -> 1; with 0x07 -> 0. Toggling odd_mode during SHIFT does not change the result.
4. Backpressure: 0x01 accepted, out_ready=0 for 5 cycles -> out_valid stays 1 and out_parity stays 1, with in_ready=0 throughout. out_ready=1 -> out_valid drops next cycle and in_ready rises.
5. Back-to-back: in_valid held high with words 0x03 then 0x80 -> results 0, 1. Accepts are spaced exactly 10 cycles apart. in_data changed during SHIFT is ignored.
6. Reset mid-operation: accept 0xFF, assert rst_n=0 at fold cycle 4 -> immediately in_ready=1, out_valid=0. No stale result appears after release. Next word 0x01 -> out_parity=1.
